// File: rtl/serial_link_xcvr_if.sv
// Frame-side and pin-side signals of the serial link transceiver.
// The slave modport is the transceiver; master is whatever drives it.
interface serial_link_xcvr_if #(
   parameter int unsigned WIDTH = 256
);

   logic             startTransfer;
   logic             readyForSend;
   logic [WIDTH-1:0] sendBuffer;
   logic             txBusy;
   logic             txDone;
   logic             clkOut;
   logic             dataOut;
   logic             clkIn;
   logic             dataIn;
   logic [WIDTH-1:0] receiveBuffer;
   logic             newData;
   logic             rxError;

   modport master (
      output startTransfer, readyForSend, sendBuffer, clkIn, dataIn,
      input  txBusy, txDone, clkOut, dataOut, receiveBuffer, newData, rxError
   );

   modport slave (
      input  startTransfer, readyForSend, sendBuffer, clkIn, dataIn,
      output txBusy, txDone, clkOut, dataOut, receiveBuffer, newData, rxError
   );

endinterface

// File: rtl/serial_link_xcvr.sv
// Full-duplex synchronous serial transceiver: TX serialises a latched frame with a
// forwarded clock; RX oversamples the remote clock/data and rebuilds frames with an idle timeout.
module serial_link_xcvr #(
   parameter int unsigned WIDTH      = 256,
   parameter int unsigned CLK_DIV    = 8,
   parameter bit          LSB_FIRST  = 1'b1,
   parameter int unsigned RX_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   serial_link_xcvr_if.slave  bus
);

   localparam int unsigned BIT_W  = $clog2(WIDTH);
   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned RXC_W  = $clog2(WIDTH + 1);
   localparam int unsigned IDLE_W = $clog2(RX_TIMEOUT + 1);
   localparam int unsigned HALF   = CLK_DIV / 2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SHIFT = 2'd1,
      TX_DONE  = 2'd2
   } tx_state_e;

   tx_state_e          tx_state_q, tx_state_d;
   logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               tx_busy_q, tx_busy_d;
   logic               tx_done_q, tx_done_d;
   logic               clk_out_q, clk_out_d;
   logic               data_out_q, data_out_d;

   logic [2:0]         clk_sync_q, clk_sync_d;
   logic [1:0]         data_sync_q, data_sync_d;
   logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic [RXC_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic [WIDTH-1:0]   rx_buf_q, rx_buf_d;
   logic               new_data_q, new_data_d;
   logic               rx_error_q, rx_error_d;

   logic [BIT_W-1:0]   tx_idx_c;
   logic [BIT_W-1:0]   rx_idx_c;
   logic               rx_rise_c;

   // Bit position on the wire for the current TX and RX counts.
   always_comb begin
      tx_idx_c = LSB_FIRST ? bit_cnt_q : BIT_W'(WIDTH - 1) - bit_cnt_q;
      rx_idx_c = LSB_FIRST ? BIT_W'(rx_cnt_q) : BIT_W'(WIDTH - 1) - BIT_W'(rx_cnt_q);
      rx_rise_c = clk_sync_q[1] & ~clk_sync_q[2];
   end

   // TX next state: outputs lag the divider by one cycle, so the clkOut rise lands mid-bit.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = 1'b0;
      clk_out_d  = clk_out_q;
      data_out_d = data_out_q;

      unique case (tx_state_q)
         TX_IDLE: begin
            clk_out_d  = 1'b0;
            data_out_d = 1'b0;
            tx_busy_d  = 1'b0;
            if (bus.startTransfer && bus.readyForSend) begin
               tx_shift_d = bus.sendBuffer;
               bit_cnt_d  = '0;
               div_cnt_d  = '0;
               tx_busy_d  = 1'b1;
               tx_state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (div_cnt_q == '0) begin
               data_out_d = tx_shift_q[tx_idx_c];
            end
            clk_out_d = (div_cnt_q >= DIV_W'(HALF));
            if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
               div_cnt_d = '0;
               if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                  // busy drops as the last bit period closes; DONE then clears the pins
                  tx_busy_d  = 1'b0;
                  tx_state_d = TX_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         TX_DONE: begin
            clk_out_d  = 1'b0;
            data_out_d = 1'b0;
            tx_done_d  = 1'b1;
            tx_busy_d  = 1'b0;
            tx_state_d = TX_IDLE;
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   // RX next state: synchronise, capture on clkIn rise, commit a full frame one cycle later.
   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], bus.clkIn};
      data_sync_d = {data_sync_q[0], bus.dataIn};
      rx_shift_d  = rx_shift_q;
      rx_cnt_d    = rx_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      rx_buf_d    = rx_buf_q;
      new_data_d  = 1'b0;
      rx_error_d  = 1'b0;

      if (rx_cnt_q == RXC_W'(WIDTH)) begin
         rx_buf_d   = rx_shift_q;
         new_data_d = 1'b1;
         rx_cnt_d   = '0;
         idle_cnt_d = '0;
      end else if (rx_rise_c) begin
         rx_shift_d[rx_idx_c] = data_sync_q[1];
         rx_cnt_d             = rx_cnt_q + 1'b1;
         idle_cnt_d           = '0;
      end else if (rx_cnt_q != '0) begin
         if (idle_cnt_q == IDLE_W'(RX_TIMEOUT - 1)) begin
            rx_shift_d = '0;
            rx_cnt_d   = '0;
            idle_cnt_d = '0;
            rx_error_d = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q  <= TX_IDLE;
         tx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         clk_out_q   <= 1'b0;
         data_out_q  <= 1'b0;
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         rx_shift_q  <= '0;
         rx_cnt_q    <= '0;
         idle_cnt_q  <= '0;
         rx_buf_q    <= '0;
         new_data_q  <= 1'b0;
         rx_error_q  <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_shift_q  <= tx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         tx_busy_q   <= tx_busy_d;
         tx_done_q   <= tx_done_d;
         clk_out_q   <= clk_out_d;
         data_out_q  <= data_out_d;
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         rx_shift_q  <= rx_shift_d;
         rx_cnt_q    <= rx_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         rx_buf_q    <= rx_buf_d;
         new_data_q  <= new_data_d;
         rx_error_q  <= rx_error_d;
      end
   end

   assign bus.txBusy        = tx_busy_q;
   assign bus.txDone        = tx_done_q;
   assign bus.clkOut        = clk_out_q;
   assign bus.dataOut       = data_out_q;
   assign bus.receiveBuffer = rx_buf_q;
   assign bus.newData       = new_data_q;
   assign bus.rxError       = rx_error_q;

endmodule
